// File: rtl/byte_pack_stage_if.sv
// Handshake bundle for byte_pack_stage: narrow input stream in, packed word stream out.
// No logic of its own; pure wiring between producer, packer and consumer.
// Optional out_parity member exists only when PACK_PARITY_EN is defined.
interface byte_pack_stage_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
);
   localparam int LW = $clog2(LANES + 1);

   logic [WIDTH-1:0]       in_data;
   logic                   in_valid;
   logic                   in_last;
   logic                   in_ready;
   logic [WIDTH*LANES-1:0] out_data;
   logic [LW-1:0]          out_lanes;
   logic                   out_valid;
   logic                   out_ready;
   logic [15:0]            out_words;
`ifdef PACK_PARITY_EN
   logic [LANES-1:0]       out_parity;
`endif

   // producer/consumer side (testbench or surrounding logic)
   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_lanes, out_valid, out_words
`ifdef PACK_PARITY_EN
      , input out_parity
`endif
   );

   // packer side
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_lanes, out_valid, out_words
`ifdef PACK_PARITY_EN
      , output out_parity
`endif
   );
endinterface

// File: rtl/byte_pack_stage.sv
// Packs LANES consecutive WIDTH-bit words into one wide word (lane 0 in LSBs); in_last flushes early.
// Latency: word completed at edge N is visible on out_data/out_valid in cycle N+1; full rate with out_ready high.
// Backpressure: single output slot; in_ready = !out_valid || out_ready, fill state frozen while held. Option: PACK_PARITY_EN.
module byte_pack_stage #(
   parameter int WIDTH = 8,
   parameter int LANES = 4   // must be >= 2
) (
   input  logic             clk,
   input  logic             reset,
   byte_pack_stage_if.slave bus
);
   localparam int IW = $clog2(LANES);
   localparam int LW = $clog2(LANES + 1);
   localparam int DW = WIDTH * LANES;

   logic [DW-1:0] fill;
   logic [DW-1:0] merged;
   logic [IW-1:0] idx;
   logic [DW-1:0] data_q;
   logic [LW-1:0] lanes_q;
   logic          valid_q;
   logic [15:0]   words_q;
   logic          ready;
   logic          accept;
   logic          complete;
   logic          xfer;

   assign ready    = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && ready;
   assign complete = accept && ((idx == IW'(LANES - 1)) || bus.in_last);
   assign xfer     = valid_q && bus.out_ready;

   // fill register with the incoming word dropped into lane idx; lanes above idx are already zero
   always_comb begin
      merged = fill;
      for (int i = 0; i < LANES; i++) begin
         if (idx == IW'(i)) begin
            merged[i*WIDTH +: WIDTH] = bus.in_data;
         end
      end
   end

   // lane fill, output slot load/clear and transfer counter
   always_ff @(posedge clk) begin
      if (reset) begin
         fill    <= '0;
         idx     <= '0;
         data_q  <= '0;
         lanes_q <= '0;
         valid_q <= 1'b0;
         words_q <= '0;
      end else begin
         if (complete) begin
            data_q  <= merged;
            lanes_q <= LW'(idx) + LW'(1);
            valid_q <= 1'b1;
            idx     <= '0;
            fill    <= '0;
         end else begin
            if (accept) begin
               fill <= merged;
               idx  <= idx + IW'(1);
            end
            if (xfer) begin
               valid_q <= 1'b0;
            end
         end
         if (xfer) begin
            words_q <= words_q + 16'd1;
         end
      end
   end

`ifdef PACK_PARITY_EN
   logic [LANES-1:0] par_next;
   logic [LANES-1:0] par_q;

   // per-lane parity of the word about to be loaded
   always_comb begin
      par_next = '0;
      for (int i = 0; i < LANES; i++) begin
         par_next[i] = ^merged[i*WIDTH +: WIDTH];
      end
   end

   // parity is loaded on the same edge as out_data so it holds with it under backpressure
   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= '0;
      end else if (complete) begin
         par_q <= par_next;
      end
   end

   assign bus.out_parity = par_q;
`endif

   assign bus.in_ready  = ready;
   assign bus.out_data  = data_q;
   assign bus.out_lanes = lanes_q;
   assign bus.out_valid = valid_q;
   assign bus.out_words = words_q;
endmodule

// File: tb/tb_byte_pack_stage.sv
// Directed bench for byte_pack_stage: packing, flush, backpressure, back-to-back, reset, wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time unit after rising.
// A monitor records every output transfer for comparison against hand-computed words.
module tb_byte_pack_stage;
   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int DW    = WIDTH * LANES;
   localparam int LW    = $clog2(LANES + 1);

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] got_data[$];
   logic [LW-1:0] got_lanes[$];

   always #5 clk = ~clk;

   byte_pack_stage_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   byte_pack_stage #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // record transfers that will happen at the coming rising edge
   always begin
      @(negedge clk);
      #1;
      if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         got_data.push_back(bus.out_data);
         got_lanes.push_back(bus.out_lanes);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic last);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready=%b required 1 within 50 cycles (data %h)", bus.in_ready, d);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic clear_q();
      got_data.delete();
      got_lanes.delete();
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b0;
      do_reset();
      checks++; if (bus.out_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'h0)   begin errors++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
      checks++; if (bus.out_lanes !== 3'd0)   begin errors++; $display("FAIL rst_lanes: got %0d want 0", bus.out_lanes); end
      checks++; if (bus.out_words !== 16'h0)  begin errors++; $display("FAIL rst_words: got %h want 0", bus.out_words); end
      checks++; if (bus.in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_full_words();
      clear_q();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (got_data.size() != 2) begin
         errors++; $display("FAIL full_count: got %0d words want 2", got_data.size());
      end else begin
         checks++; if (got_data[0] !== 32'h04030201) begin errors++; $display("FAIL full_w0: got %h want 04030201", got_data[0]); end
         checks++; if (got_data[1] !== 32'h08070605) begin errors++; $display("FAIL full_w1: got %h want 08070605", got_data[1]); end
         checks++; if (got_lanes[0] !== 3'd4 || got_lanes[1] !== 3'd4) begin errors++; $display("FAIL full_lanes: got %0d,%0d want 4,4", got_lanes[0], got_lanes[1]); end
      end
      checks++; if (bus.out_words !== 16'd2) begin errors++; $display("FAIL full_words: got %0d want 2", bus.out_words); end
   endtask

   task automatic test_last_flush();
      clear_q();
      bus.out_ready = 1'b1;
      push(8'hAA, 1'b0);
      push(8'hBB, 1'b0);
      push(8'hCC, 1'b1);
      checks++; if (bus.out_lanes !== 3'd3) begin errors++; $display("FAIL flush_lanes: got %0d want 3", bus.out_lanes); end
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      push(8'h44, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (got_data.size() != 2) begin
         errors++; $display("FAIL flush_count: got %0d words want 2", got_data.size());
      end else begin
         checks++; if (got_data[0] !== 32'h00CCBBAA) begin errors++; $display("FAIL flush_w0: got %h want 00ccbbaa", got_data[0]); end
         checks++; if (got_lanes[0] !== 3'd3) begin errors++; $display("FAIL flush_l0: got %0d want 3", got_lanes[0]); end
         checks++; if (got_data[1] !== 32'h44332211) begin errors++; $display("FAIL flush_next: got %h want 44332211", got_data[1]); end
      end
      checks++; if (bus.out_words !== 16'd4) begin errors++; $display("FAIL flush_words: got %0d want 4", bus.out_words); end
   endtask

   task automatic test_backpressure();
      clear_q();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201) begin
            errors++; $display("FAIL bp_hold[%0d]: valid %b data %h want 1 04030201", c, bus.out_valid, bus.out_data);
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h11;
      bus.in_last   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      push(8'h44, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (got_data.size() != 2) begin
         errors++; $display("FAIL bp_count: got %0d words want 2", got_data.size());
      end else begin
         checks++; if (got_data[0] !== 32'h04030201) begin errors++; $display("FAIL bp_w0: got %h want 04030201", got_data[0]); end
         checks++; if (got_data[1] !== 32'h44332211) begin errors++; $display("FAIL bp_w1: got %h want 44332211", got_data[1]); end
      end
      checks++; if (bus.out_words !== 16'd6) begin errors++; $display("FAIL bp_words: got %0d want 6", bus.out_words); end
   endtask

   task automatic test_back_to_back();
      clear_q();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         push(8'(i), 1'b0);
         if (i == 4 || i == 8) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_after_%0d: got %b want 1", i, bus.out_valid); end
         end
      end
      push(8'h21, 1'b1);
      push(8'h22, 1'b1);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000022) begin
         errors++; $display("FAIL b2b_last_22: valid %b data %h want 1 00000022", bus.out_valid, bus.out_data);
      end
      push(8'h23, 1'b1);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000023) begin
         errors++; $display("FAIL b2b_last_23: valid %b data %h want 1 00000023", bus.out_valid, bus.out_data);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (got_data.size() != 6) begin
         errors++; $display("FAIL b2b_count: got %0d words want 6", got_data.size());
      end else begin
         checks++; if (got_data[0] !== 32'h04030201) begin errors++; $display("FAIL b2b_w0: got %h want 04030201", got_data[0]); end
         checks++; if (got_data[1] !== 32'h08070605) begin errors++; $display("FAIL b2b_w1: got %h want 08070605", got_data[1]); end
         checks++; if (got_data[2] !== 32'h0C0B0A09) begin errors++; $display("FAIL b2b_w2: got %h want 0c0b0a09", got_data[2]); end
         checks++; if (got_data[3] !== 32'h00000021 || got_lanes[3] !== 3'd1) begin
            errors++; $display("FAIL b2b_w3: got %h/%0d want 00000021/1", got_data[3], got_lanes[3]);
         end
         checks++; if (got_data[5] !== 32'h00000023 || got_lanes[5] !== 3'd1) begin
            errors++; $display("FAIL b2b_w5: got %h/%0d want 00000023/1", got_data[5], got_lanes[5]);
         end
      end
      checks++; if (bus.out_words !== 16'd12) begin errors++; $display("FAIL b2b_words: got %0d want 12", bus.out_words); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      do_reset();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_words !== 16'd0) begin
         errors++; $display("FAIL rmid1: valid %b words %0d want 0 0", bus.out_valid, bus.out_words);
      end
      bus.out_ready = 1'b0;
      for (int i = 5; i <= 8; i++) push(8'(i), 1'b0);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b want 1", bus.out_valid); end
      do_reset();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_words !== 16'd0 || bus.out_lanes !== 3'd0) begin
         errors++; $display("FAIL rmid2: valid %b words %0d lanes %0d want 0 0 0", bus.out_valid, bus.out_words, bus.out_lanes);
      end
      clear_q();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (got_data.size() != 1) begin
         errors++; $display("FAIL rmid_count: got %0d words want 1", got_data.size());
      end else begin
         checks++; if (got_data[0] !== 32'h04030201 || got_lanes[0] !== 3'd4) begin
            errors++; $display("FAIL rmid_word: got %h/%0d want 04030201/4", got_data[0], got_lanes[0]);
         end
      end
      checks++; if (bus.out_words !== 16'd1) begin errors++; $display("FAIL rmid_words: got %0d want 1", bus.out_words); end
   endtask

   task automatic test_wrap();
      bus.out_ready = 1'b1;
      @(negedge clk);
      force dut.words_q = 16'hFFFF;
      #1;
      release dut.words_q;
      checks++; if (bus.out_words !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want ffff", bus.out_words); end
      push(8'h55, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.out_words !== 16'h0000) begin errors++; $display("FAIL wrap_post: got %h want 0000", bus.out_words); end
   endtask

`ifdef PACK_PARITY_EN
   task automatic test_parity();
      bus.out_ready = 1'b0;
      push(8'h01, 1'b0);
      push(8'h03, 1'b0);
      push(8'h07, 1'b0);
      push(8'hFF, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (bus.out_parity !== 4'b0101) begin errors++; $display("FAIL par_full: got %b want 0101", bus.out_parity); end
      bus.out_ready = 1'b1;
      push(8'h01, 1'b1);
      checks++; if (bus.out_parity !== 4'b0001) begin errors++; $display("FAIL par_one_lane: got %b want 0001", bus.out_parity); end
      @(negedge clk);
   endtask
`endif

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_full_words();
      test_last_flush();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
`ifdef PACK_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/byte_pack_stage.md
# byte_pack_stage

Downstream consumer for the per-bit inverter stage: accepts its WIDTH-bit output one word per cycle over a valid/ready handshake. Packs LANES consecutive words into one wide output word, lane 0 in the LSBs. An in_last marker flushes a partially filled word early. A single registered output slot drives a valid/ready handshake, and a wrapping counter reports completed transfers.

## Interface
- WIDTH, 8: bits per input word / per lane.
- LANES, 4: lanes per packed word; must be ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word from the inverter stage.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  this word closes the packed word (flush).
- in_ready  output  1  stage accepts input this cycle.
- out_data  output  WIDTH*LANES  packed word; lane i at [WIDTH*i +: WIDTH].
- out_lanes  output  $clog2(LANES+1)  number of filled lanes in out_data (1..LANES).
- out_valid  output  1  out_data/out_lanes valid.
- out_ready  input  1  consumer accepts output.
- out_words  output  16  count of completed output transfers; wraps.

## Operation
- Internal state:
  - fill register: WIDTH*LANES bits.
  - lane index idx: 0..LANES-1.
  - one output slot holding out_data, out_lanes, out_valid.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; in_ready does not depend on in_valid.
- Accept: in_valid && in_ready. An accepted word is written to fill lane idx.
- Complete: an accept with idx == LANES-1 or in_last == 1.
  - The output slot loads the fill register with this word merged in.
  - Lanes above the current idx load as zero.
  - out_lanes = idx+1 and out_valid = 1.
  - idx returns to 0 and the fill register clears.
- Non-completing accept: idx increments.
- Output transfer: out_valid && out_ready.
  - If there is no simultaneous complete, out_valid clears.
  - With a simultaneous complete, the new word loads and out_valid stays 1 (back-to-back throughput).
- Hold: while out_valid && !out_ready, out_data and out_lanes are stable and in_ready = 0. The fill state is frozen.
- out_words increments by 1 on each output transfer, 0xFFFF → 0x0000.
- in_last on lane 0 produces a 1-lane word (out_lanes = 1).
- Reset values:
  - out_valid = 0, out_data = 0, out_lanes = 0, out_words = 0.
  - idx = 0, fill register = 0.
  - in_ready is therefore 1 after reset.
- Reset mid-operation discards any partial fill and any pending output word; nothing is emitted for them.

## Timing
- Latency: a complete at edge N gives out_valid = 1 and the word visible after edge N, i.e. in cycle N+1.
- Full-rate throughput with out_ready held high: one output word every LANES accepted inputs (fewer with in_last).
- No combinational path from in_data/in_valid/in_last to any output. out_ready → in_ready is the only combinational path.
- Reset has priority over all other events at the same edge.

## Configuration
- PACK_PARITY_EN defined:
  - Adds output port out_parity, LANES bits.
  - Bit i is the XOR of lane i of out_data, loaded in the same edge as out_data.
  - Unfilled (zero) lanes give parity 0.
  - Reset value is 0.
  - Held stable under backpressure with out_data.
- PACK_PARITY_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then 8 inputs 0x01..0x08 with out_ready = 1 → out_data 0x04030201 then 0x08070605, out_lanes 4 each, out_words = 2.
- Inputs 0xAA, 0xBB, 0xCC with in_last on 0xCC → out_data 0x00CCBBAA, out_lanes 3, next word starts at lane 0.
- Backpressure: complete 0x04030201, then hold out_ready = 0 for 5 cycles → in_ready = 0 and out_data stable. Raise out_ready together with input 0x11 → transfer occurs, 0x11 lands in lane 0.
- Back-to-back: out_ready = 1, continuous valid input 0x01..0x0C → three words, out_valid never drops between the 4th and 5th and between the 8th and 9th accepts.
- Reset asserted after 2 accepted inputs and again while out_valid = 1 → out_valid = 0, out_words = 0, next inputs 0x01..0x04 give exactly 0x04030201.
- With PACK_PARITY_EN: inputs 0x01, 0x03, 0x07, 0xFF → out_parity = 4'b0101 (lane 0 in bit 0); force out_words from 0xFFFF with one transfer → wraps to 0x0000.
